// File: rtl/seq_csel_subtractor.sv
// Multi-cycle carry-select subtractor: d = a - b - bin, one CHUNK-bit slice per clock,
// LSB slice first, with a start/busy/done handshake.
module seq_csel_subtractor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] nb_sl;
    logic [CHUNK:0]   s0;
    logic [CHUNK:0]   s1;
    logic [CHUNK:0]   sel;
    logic [WIDTH-1:0] acc_nxt;
    logic             ovf_nxt;

    // Current slice: both carry hypotheses, carry-selected sum merged into the accumulator
    always_comb begin
        a_sl    = '0;
        nb_sl   = '0;
        acc_nxt = acc;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            if (idx == IDXW'(i)) begin
                a_sl  = a_q[i*CHUNK +: CHUNK];
                nb_sl = ~b_q[i*CHUNK +: CHUNK];
            end
        end
        s0  = {1'b0, a_sl} + {1'b0, nb_sl};
        s1  = s0 + (CHUNK+1)'(1);
        sel = carry ? s1 : s0;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            if (idx == IDXW'(i)) begin
                acc_nxt[i*CHUNK +: CHUNK] = sel[CHUNK-1:0];
            end
        end
        ovf_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
    end

    // Handshake FSM, slice sequencing and registered results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= ~bin;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    carry <= sel[CHUNK];
                    idx   <= idx + IDXW'(1);
                    if (idx == IDXW'(NCHUNK - 1)) begin
                        d     <= acc_nxt;
                        bout  <= ~sel[CHUNK];
                        ovf   <= ovf_nxt;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
